// File: rtl/hazard_unit_cfg.sv
// Hazard unit for the 5-stage RV32I pipeline.
// Provides EX-stage operand forwarding, multi-cycle load-use stalls and
// control-flow handling. Control flow uses either an always-stall branch shadow
// (BR_MODE 0) or predict-not-taken with a flush on redirect (BR_MODE 1).
// A bubble counter tracks the number of cycles that have any stall or flush active.
module hazard_unit_cfg #(
  parameter int unsigned BR_MODE      = 0,
  parameter int unsigned BR_RES_LAT   = 2,
  parameter int unsigned LD_STALL_CYC = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [6:0]       i_opcode_if,
  input  logic             i_valid_if,
  input  logic [4:0]       i_rs1_d,
  input  logic [4:0]       i_rs2_d,
  input  logic [4:0]       i_rs1_e,
  input  logic [4:0]       i_rs2_e,
  input  logic [4:0]       i_ex_rd,
  input  logic [4:0]       i_mem_rd,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_ex_regwrite,
  input  logic             i_mem_regwrite,
  input  logic             i_wb_regwrite,
  input  logic             i_ex_is_load,
  input  logic             i_redirect,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic             o_flush_mem,
  output logic [1:0]       o_forward_a,
  output logic [1:0]       o_forward_b,
  output logic             o_br_pending,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEM   = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b01;

  // Reject unsupported configurations at elaboration
  if (BR_MODE > 1) begin : g_bad_mode
    $error("hazard_unit_cfg: BR_MODE must be 0 or 1");
  end
  if (BR_RES_LAT != 2 && BR_RES_LAT != 3) begin : g_bad_lat
    $error("hazard_unit_cfg: BR_RES_LAT must be 2 or 3");
  end
  if (LD_STALL_CYC < 1 || LD_STALL_CYC > 3) begin : g_bad_ld
    $error("hazard_unit_cfg: LD_STALL_CYC must be in 1..3");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("hazard_unit_cfg: CNT_W must be at least 1");
  end

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SHADOW = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sh_cnt_q, sh_cnt_d;
  logic [1:0]       ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic       ctrl_if_c;
  logic       ld_hit_c;
  logic       ld_stall_c;
  logic       redirect_m1_c;
  logic       stall_f_c, stall_d_c, flush_d_c, flush_e_c, flush_mem_c;
  logic       any_bubble_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  // Operand forwarding: MEM result takes priority over WB; x0 is never forwarded
  always_comb begin
    fwd_a_c = FWD_RF;
    fwd_b_c = FWD_RF;
    if (i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_rs1_e)) begin
      fwd_a_c = FWD_MEM;
    end else if (i_wb_regwrite && (i_wb_rd != 5'd0) && (i_wb_rd == i_rs1_e)) begin
      fwd_a_c = FWD_WB;
    end
    if (i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_rs2_e)) begin
      fwd_b_c = FWD_MEM;
    end else if (i_wb_regwrite && (i_wb_rd != 5'd0) && (i_wb_rd == i_rs2_e)) begin
      fwd_b_c = FWD_WB;
    end
  end

  // Hazard detection terms
  always_comb begin
    ctrl_if_c     = i_valid_if && ((i_opcode_if == OP_BRANCH) ||
                                   (i_opcode_if == OP_JAL)    ||
                                   (i_opcode_if == OP_JALR));
    ld_hit_c      = i_ex_is_load && i_ex_regwrite && (i_ex_rd != 5'd0) &&
                    ((i_ex_rd == i_rs1_d) || (i_ex_rd == i_rs2_d));
    ld_stall_c    = ld_hit_c || (ld_cnt_q != 2'd0);
    redirect_m1_c = (BR_MODE == 1) && i_redirect;
  end

  // Load-use bubble counter; a predicted-path redirect discards the pending stall
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    if (redirect_m1_c) begin
      ld_cnt_d = 2'd0;
    end else if (ld_cnt_q != 2'd0) begin
      ld_cnt_d = ld_cnt_q - 2'd1;
    end else if (ld_hit_c) begin
      ld_cnt_d = 2'(LD_STALL_CYC - 1);
    end
  end

  // Branch-shadow FSM next state and the stall/flush controls
  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    stall_f_c   = 1'b0;
    stall_d_c   = 1'b0;
    flush_d_c   = 1'b0;
    flush_e_c   = 1'b0;
    flush_mem_c = 1'b0;

    if (BR_MODE == 0) begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_if_c && !ld_stall_c) begin
            state_d  = ST_SHADOW;
            sh_cnt_d = 2'(BR_RES_LAT);
          end
        end
        ST_SHADOW: begin
          // A load stall holds the branch in ID, so the shadow is frozen
          if (!ld_stall_c) begin
            if (sh_cnt_q > 2'd1) begin
              stall_f_c = 1'b1;
              flush_d_c = 1'b1;
              sh_cnt_d  = sh_cnt_q - 2'd1;
            end else begin
              flush_d_c = i_redirect;
              if (BR_RES_LAT == 3) begin
                flush_e_c = i_redirect;
              end
              sh_cnt_d = 2'd0;
              state_d  = ST_IDLE;
            end
          end
        end
        default: begin
          state_d  = ST_IDLE;
          sh_cnt_d = 2'd0;
        end
      endcase
    end

    if (ld_stall_c) begin
      stall_f_c = 1'b1;
      stall_d_c = 1'b1;
      flush_e_c = 1'b1;
    end

    // Wrong-path squash wins over any load stall
    if (redirect_m1_c) begin
      stall_f_c   = 1'b0;
      stall_d_c   = 1'b0;
      flush_d_c   = 1'b1;
      flush_e_c   = 1'b1;
      flush_mem_c = (BR_RES_LAT == 3);
    end
  end

  // Bubble counter next value, wrapping naturally at 2^CNT_W
  always_comb begin
    any_bubble_c = stall_f_c || stall_d_c || flush_d_c || flush_e_c || flush_mem_c;
    bubble_cnt_d = bubble_cnt_q;
    if (any_bubble_c) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      sh_cnt_q     <= 2'd0;
      ld_cnt_q     <= 2'd0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      ld_cnt_q     <= ld_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Outputs are forced low for as long as reset is held
  always_comb begin
    o_stall_f    = stall_f_c   && !i_reset;
    o_stall_d    = stall_d_c   && !i_reset;
    o_flush_d    = flush_d_c   && !i_reset;
    o_flush_e    = flush_e_c   && !i_reset;
    o_flush_mem  = flush_mem_c && !i_reset;
    o_forward_a  = i_reset ? FWD_RF : fwd_a_c;
    o_forward_b  = i_reset ? FWD_RF : fwd_b_c;
    o_br_pending = (state_q == ST_SHADOW) && !i_reset;
    o_bubble_cnt = bubble_cnt_q;
  end

endmodule

// File: tb/tb_hazard_unit_cfg.sv
// Bench for hazard_unit_cfg: three configurations share one stimulus stream.
//   u0: mode 0, resolve latency 2, 2-cycle load stall
//   u1: mode 0, resolve latency 3, 1-cycle load stall
//   u2: mode 1, resolve latency 3, 3-cycle load stall
// The stimulus pushes expected values to a scoreboard, which is popped on the falling clock edge.
module tb_hazard_unit_cfg;

  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // {stall_f, stall_d, flush_d, flush_e, flush_mem, br_pending, fwd_a, fwd_b}
  localparam logic [9:0] Z    = 10'b00000_0_00_00;
  localparam logic [9:0] LDV  = 10'b11010_0_00_00;
  localparam logic [9:0] SH   = 10'b10100_1_00_00;
  localparam logic [9:0] PEND = 10'b00000_1_00_00;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] opcode_if;
  logic valid_if;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, ex_rd, mem_rd, wb_rd;
  logic ex_rw, mem_rw, wb_rw, ex_is_load, redirect;

  logic        stall_f [3];
  logic        stall_d [3];
  logic        flush_d [3];
  logic        flush_e [3];
  logic        flush_mem [3];
  logic        br_pend [3];
  logic [1:0]  fwd_a [3];
  logic [1:0]  fwd_b [3];
  logic [31:0] bcnt [3];

  int n_checks = 0;
  int n_fail   = 0;

  int          q_inst [$];
  logic [9:0]  q_ctl [$];
  bit          q_chk [$];
  logic [31:0] q_cnt [$];
  string       q_tag [$];

  always #5 clk = ~clk;

  hazard_unit_cfg #(.BR_MODE(0), .BR_RES_LAT(2), .LD_STALL_CYC(2), .CNT_W(32)) u0 (
    .i_clk(clk), .i_reset(rst), .i_opcode_if(opcode_if), .i_valid_if(valid_if),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
    .i_ex_rd(ex_rd), .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
    .i_ex_regwrite(ex_rw), .i_mem_regwrite(mem_rw), .i_wb_regwrite(wb_rw),
    .i_ex_is_load(ex_is_load), .i_redirect(redirect),
    .o_stall_f(stall_f[0]), .o_stall_d(stall_d[0]), .o_flush_d(flush_d[0]),
    .o_flush_e(flush_e[0]), .o_flush_mem(flush_mem[0]),
    .o_forward_a(fwd_a[0]), .o_forward_b(fwd_b[0]),
    .o_br_pending(br_pend[0]), .o_bubble_cnt(bcnt[0]));

  hazard_unit_cfg #(.BR_MODE(0), .BR_RES_LAT(3), .LD_STALL_CYC(1), .CNT_W(32)) u1 (
    .i_clk(clk), .i_reset(rst), .i_opcode_if(opcode_if), .i_valid_if(valid_if),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
    .i_ex_rd(ex_rd), .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
    .i_ex_regwrite(ex_rw), .i_mem_regwrite(mem_rw), .i_wb_regwrite(wb_rw),
    .i_ex_is_load(ex_is_load), .i_redirect(redirect),
    .o_stall_f(stall_f[1]), .o_stall_d(stall_d[1]), .o_flush_d(flush_d[1]),
    .o_flush_e(flush_e[1]), .o_flush_mem(flush_mem[1]),
    .o_forward_a(fwd_a[1]), .o_forward_b(fwd_b[1]),
    .o_br_pending(br_pend[1]), .o_bubble_cnt(bcnt[1]));

  hazard_unit_cfg #(.BR_MODE(1), .BR_RES_LAT(3), .LD_STALL_CYC(3), .CNT_W(32)) u2 (
    .i_clk(clk), .i_reset(rst), .i_opcode_if(opcode_if), .i_valid_if(valid_if),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
    .i_ex_rd(ex_rd), .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
    .i_ex_regwrite(ex_rw), .i_mem_regwrite(mem_rw), .i_wb_regwrite(wb_rw),
    .i_ex_is_load(ex_is_load), .i_redirect(redirect),
    .o_stall_f(stall_f[2]), .o_stall_d(stall_d[2]), .o_flush_d(flush_d[2]),
    .o_flush_e(flush_e[2]), .o_flush_mem(flush_mem[2]),
    .o_forward_a(fwd_a[2]), .o_forward_b(fwd_b[2]),
    .o_br_pending(br_pend[2]), .o_bubble_cnt(bcnt[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] obs(input int k);
    return {stall_f[k], stall_d[k], flush_d[k], flush_e[k], flush_mem[k],
            br_pend[k], fwd_a[k], fwd_b[k]};
  endfunction

  // Scoreboard drain: compare every queued expectation against this cycle's outputs
  int          sb_k;
  logic [9:0]  sb_ctl;
  bit          sb_chk;
  logic [31:0] sb_cnt;
  string       sb_tag;
  always @(negedge clk) begin
    while (q_inst.size() > 0) begin
      sb_k   = q_inst.pop_front();
      sb_ctl = q_ctl.pop_front();
      sb_chk = q_chk.pop_front();
      sb_cnt = q_cnt.pop_front();
      sb_tag = q_tag.pop_front();
      check(sb_tag, 32'(obs(sb_k)), 32'(sb_ctl));
      if (sb_chk) check({sb_tag, "_cnt"}, bcnt[sb_k], sb_cnt);
    end
  end

  task automatic exp_ctl(input int k, input string tag, input logic [9:0] ctl);
    q_inst.push_back(k); q_ctl.push_back(ctl); q_chk.push_back(1'b0);
    q_cnt.push_back(32'd0); q_tag.push_back(tag);
  endtask

  task automatic exp_cnt(input int k, input string tag, input logic [9:0] ctl,
                         input logic [31:0] c);
    q_inst.push_back(k); q_ctl.push_back(ctl); q_chk.push_back(1'b1);
    q_cnt.push_back(c); q_tag.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    opcode_if = 7'd0; valid_if = 1'b0;
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
    ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    ex_rw = 1'b0; mem_rw = 1'b0; wb_rw = 1'b0; ex_is_load = 1'b0; redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();

    // Reset held with every hazard input active: all outputs must stay 0
    rs1_e = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5; mem_rw = 1'b1; wb_rw = 1'b1;
    ex_is_load = 1'b1; ex_rw = 1'b1; ex_rd = 5'd3; rs1_d = 5'd3;
    valid_if = 1'b1; opcode_if = OP_BEQ; redirect = 1'b1;
    for (int k = 0; k < 3; k++) exp_cnt(k, "reset", Z, 32'd0);
    tick();
    rst = 1'b0;
    idle_inputs();

    // Forwarding priority and x0 guard
    rs1_e = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5; mem_rw = 1'b1; wb_rw = 1'b1;
    exp_ctl(0, "fwd_mem", 10'b00000_0_10_00);
    tick();
    mem_rw = 1'b0;
    exp_ctl(0, "fwd_wb", 10'b00000_0_01_00);
    tick();
    mem_rd = 5'd0; wb_rd = 5'd0; rs1_e = 5'd0; mem_rw = 1'b1;
    exp_ctl(0, "fwd_x0", Z);
    tick();
    rs2_e = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
    exp_ctl(0, "fwd_b_mem", 10'b00000_0_00_10);
    tick();
    mem_rd = 5'd3; rs1_e = 5'd3;
    exp_ctl(0, "fwd_mixed", 10'b00000_0_10_01);
    tick();
    idle_inputs();
    exp_cnt(0, "fwd_nobubble", Z, 32'd0);
    tick();

    // Load-use stall length per configuration
    do_reset();
    ex_is_load = 1'b1; ex_rw = 1'b1; ex_rd = 5'd3; rs1_d = 5'd3;
    exp_ctl(0, "ld2_c0", LDV);
    exp_ctl(1, "ld1_c0", LDV);
    tick();
    idle_inputs();
    exp_ctl(0, "ld2_c1", LDV);
    exp_ctl(1, "ld1_c1", Z);
    tick();
    exp_cnt(0, "ld2_end", Z, 32'd2);
    tick();
    ex_is_load = 1'b1; ex_rw = 1'b1; ex_rd = 5'd0;
    exp_ctl(0, "ld_x0", Z);
    tick();
    ex_rd = 5'd9; rs2_d = 5'd9; ex_rw = 1'b0;
    exp_ctl(0, "ld_norw", Z);
    tick();
    ex_rw = 1'b1;
    exp_ctl(0, "ld_rs2", LDV);
    tick();
    idle_inputs();
    exp_ctl(0, "ld_rs2_c1", LDV);
    tick();
    exp_ctl(0, "ld_rs2_end", Z);
    tick();

    // Mode 0, beq not taken, both resolve latencies
    do_reset();
    opcode_if = OP_BEQ; valid_if = 1'b0;
    exp_ctl(0, "ctl_invalid", Z);
    tick();
    valid_if = 1'b1;
    exp_ctl(0, "beq_detect", Z);
    exp_ctl(1, "beq3_detect", Z);
    tick();
    idle_inputs();
    exp_ctl(0, "beq_shadow", SH);
    exp_ctl(1, "beq3_s1", SH);
    exp_ctl(2, "m1_noshadow", Z);
    tick();
    exp_ctl(0, "beq_resolve", PEND);
    exp_ctl(1, "beq3_s2", SH);
    tick();
    exp_cnt(0, "beq_done", Z, 32'd1);
    exp_ctl(1, "beq3_resolve", PEND);
    tick();
    exp_cnt(1, "beq3_done", Z, 32'd2);
    tick();

    // Mode 0, taken jal; mode 1 redirect while no load is pending
    do_reset();
    opcode_if = OP_JAL; valid_if = 1'b1;
    exp_ctl(0, "jal_detect", Z);
    tick();
    idle_inputs();
    exp_ctl(0, "jal_shadow", SH);
    exp_ctl(1, "jal3_s1", SH);
    tick();
    redirect = 1'b1;
    exp_ctl(0, "jal_resolve", 10'b00100_1_00_00);
    exp_ctl(1, "jal3_s2", SH);
    exp_ctl(2, "m1_redirect", 10'b00111_0_00_00);
    tick();
    exp_ctl(0, "m0_idle_redirect", Z);
    exp_ctl(1, "jal3_resolve", 10'b00110_1_00_00);
    tick();
    redirect = 1'b0;
    exp_cnt(0, "jal_cnt", Z, 32'd2);
    exp_cnt(1, "jal3_cnt", Z, 32'd3);
    tick();

    // Mode 1: redirect overrides a coincident load-use hit
    do_reset();
    ex_is_load = 1'b1; ex_rw = 1'b1; ex_rd = 5'd4; rs2_d = 5'd4; redirect = 1'b1;
    exp_ctl(2, "m1_redir_ld", 10'b00111_0_00_00);
    tick();
    idle_inputs();
    exp_cnt(2, "m1_no_residual", Z, 32'd1);
    tick();
    ex_is_load = 1'b1; ex_rw = 1'b1; ex_rd = 5'd4; rs2_d = 5'd4;
    exp_ctl(2, "m1_ld_c0", LDV);
    tick();
    idle_inputs();
    exp_ctl(2, "m1_ld_c1", LDV);
    tick();
    exp_ctl(2, "m1_ld_c2", LDV);
    tick();
    exp_cnt(2, "m1_ld_end", Z, 32'd4);
    tick();

    // Mode 0: a load stall inside the shadow freezes it
    do_reset();
    opcode_if = OP_JALR; valid_if = 1'b1;
    exp_ctl(0, "jalr_detect", Z);
    tick();
    idle_inputs();
    ex_is_load = 1'b1; ex_rw = 1'b1; ex_rd = 5'd6; rs1_d = 5'd6;
    exp_ctl(0, "sh_ld_freeze0", 10'b11010_1_00_00);
    tick();
    idle_inputs();
    exp_ctl(0, "sh_ld_freeze1", 10'b11010_1_00_00);
    tick();
    exp_ctl(0, "sh_resume", SH);
    tick();
    exp_ctl(0, "sh_resolve", PEND);
    tick();
    exp_cnt(0, "sh_ld_cnt", Z, 32'd3);
    tick();

    // Reset in the middle of a shadow (u1 has sh_cnt == 2 in the third cycle)
    do_reset();
    opcode_if = OP_BEQ; valid_if = 1'b1;
    exp_ctl(1, "rst_detect", Z);
    tick();
    idle_inputs();
    exp_ctl(1, "rst_pre_s1", SH);
    tick();
    rst = 1'b1;
    rs1_e = 5'd5; mem_rd = 5'd5; mem_rw = 1'b1;
    exp_cnt(1, "rst_mid_shadow", Z, 32'd0);
    exp_ctl(0, "rst_mid_u0", Z);
    tick();
    rst = 1'b0;
    idle_inputs();
    opcode_if = OP_BEQ; valid_if = 1'b1;
    exp_cnt(1, "rst_release_idle", Z, 32'd0);
    tick();
    idle_inputs();
    exp_ctl(1, "rst_new_shadow", SH);
    tick();
    tick();

    check("sb_drained", 32'(q_inst.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
